// File: rtl/sd_cmd.sv
// sd_cmd: SD CMD-line engine. Sends a 48-bit command frame with CRC7, then optionally receives and checks the card response.
// Optional build macro SD_CMD_LONG_RESPONSE_EN enables 136-bit R2 reception and the full 128-bit response path.
module sd_cmd #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_sd_clk_strobe_rising,
  input  logic         i_sd_clk_strobe_falling,
  output logic         o_sd_cmd_oe,
  output logic         o_sd_cmd_out,
  input  logic         i_sd_cmd_in,
  input  logic         i_start,
  input  logic [5:0]   i_index,
  input  logic [31:0]  i_argument,
  input  logic         i_skip_response,
  input  logic         i_long_response,
  input  logic         i_ignore_crc,
  output logic         o_busy,
  output logic         o_done,
  output logic [5:0]   o_index,
  output logic [127:0] o_response,
  output logic         o_error_timeout,
  output logic         o_error_crc
);

`ifdef SD_CMD_LONG_RESPONSE_EN
  localparam int RXW = 136;
`else
  localparam int RXW = 48;
`endif

  typedef enum logic [1:0] {IDLE, TX, RX_WAIT, RX} state_t;

  state_t         state_q, state_d;
  logic [39:0]    tx_sr_q, tx_sr_d;
  logic [6:0]     crc_q, crc_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [7:0]     wait_q, wait_d;
  logic [RXW-2:0] rx_sr_q, rx_sr_d;
  logic           skip_q, skip_d;
  logic           long_q, long_d;
  logic           ign_q, ign_d;
  logic           oe_q, oe_d;
  logic           out_q, out_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [5:0]     index_q, index_d;
  logic [127:0]   resp_q, resp_d;
  logic           tout_q, tout_d;
  logic           crcerr_q, crcerr_d;

  logic [RXW-1:0] frame;
  logic [7:0]     last_idx;
  logic           crc_cover;
  logic           unused_bits;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // Complete received frame as of the bit being sampled right now (the end bit when cnt_q == last_idx).
  assign frame       = {rx_sr_q, i_sd_cmd_in};
  assign last_idx    = long_q ? 8'd135 : 8'd47;
  assign crc_cover   = long_q ? ((cnt_q >= 8'd8) && (cnt_q <= 8'd127)) : (cnt_q <= 8'd39);
  assign unused_bits = ^{frame[RXW-1:46], i_long_response};

  always_comb begin
    state_d  = state_q;
    tx_sr_d  = tx_sr_q;
    crc_d    = crc_q;
    cnt_d    = cnt_q;
    wait_d   = wait_q;
    rx_sr_d  = rx_sr_q;
    skip_d   = skip_q;
    long_d   = long_q;
    ign_d    = ign_q;
    oe_d     = oe_q;
    out_d    = out_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    index_d  = index_q;
    resp_d   = resp_q;
    tout_d   = tout_q;
    crcerr_d = crcerr_q;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          tx_sr_d  = {2'b01, i_index, i_argument};
          crc_d    = '0;
          cnt_d    = '0;
          skip_d   = i_skip_response;
`ifdef SD_CMD_LONG_RESPONSE_EN
          long_d   = i_long_response;
`else
          long_d   = 1'b0;
`endif
          ign_d    = i_ignore_crc;
          index_d  = '0;
          resp_d   = '0;
          tout_d   = 1'b0;
          crcerr_d = 1'b0;
          busy_d   = 1'b1;
          state_d  = TX;
        end
      end

      // cnt_q 0..39 payload, 40..46 CRC, 47 end bit, 48 release of the line.
      TX: begin
        if (i_sd_clk_strobe_falling) begin
          cnt_d = cnt_q + 8'd1;
          oe_d  = 1'b1;
          if (cnt_q < 8'd40) begin
            out_d   = tx_sr_q[39];
            tx_sr_d = {tx_sr_q[38:0], 1'b0};
            crc_d   = crc7_step(crc_q, tx_sr_q[39]);
          end else if (cnt_q < 8'd47) begin
            out_d = crc_q[6];
            crc_d = {crc_q[5:0], 1'b0};
          end else if (cnt_q == 8'd47) begin
            out_d = 1'b1;
          end else begin
            oe_d  = 1'b0;
            out_d = 1'b1;
            if (skip_q) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end else begin
              wait_d  = '0;
              state_d = RX_WAIT;
            end
          end
        end
      end

      RX_WAIT: begin
        if (i_sd_clk_strobe_rising) begin
          if (!i_sd_cmd_in) begin
            cnt_d   = 8'd1;
            crc_d   = '0;
            rx_sr_d = '0;
            state_d = RX;
          end else if (wait_q == 8'(TIMEOUT - 1)) begin
            tout_d  = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
      end

      RX: begin
        if (i_sd_clk_strobe_rising) begin
          rx_sr_d = {rx_sr_q[RXW-3:0], i_sd_cmd_in};
          cnt_d   = cnt_q + 8'd1;
          if (crc_cover) begin
            crc_d = crc7_step(crc_q, i_sd_cmd_in);
          end
          if (cnt_q == last_idx) begin
`ifdef SD_CMD_LONG_RESPONSE_EN
            if (long_q) begin
              resp_d = frame[127:0];
            end else begin
              index_d = frame[45:40];
              resp_d  = {96'b0, frame[39:8]};
            end
`else
            index_d = frame[45:40];
            resp_d  = {96'b0, frame[39:8]};
`endif
            crcerr_d = ((crc_q != frame[7:1]) && !ign_q) || !i_sd_cmd_in;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q  <= IDLE;
      tx_sr_q  <= '0;
      crc_q    <= '0;
      cnt_q    <= '0;
      wait_q   <= '0;
      rx_sr_q  <= '0;
      skip_q   <= 1'b0;
      long_q   <= 1'b0;
      ign_q    <= 1'b0;
      oe_q     <= 1'b0;
      out_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      index_q  <= '0;
      resp_q   <= '0;
      tout_q   <= 1'b0;
      crcerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_sr_q  <= tx_sr_d;
      crc_q    <= crc_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      rx_sr_q  <= rx_sr_d;
      skip_q   <= skip_d;
      long_q   <= long_d;
      ign_q    <= ign_d;
      oe_q     <= oe_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      index_q  <= index_d;
      resp_q   <= resp_d;
      tout_q   <= tout_d;
      crcerr_q <= crcerr_d;
    end
  end

  assign o_sd_cmd_oe     = oe_q;
  assign o_sd_cmd_out    = out_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_index         = index_q;
  assign o_response      = resp_q;
  assign o_error_timeout = tout_q;
  assign o_error_crc     = crcerr_q;

endmodule

// File: tb/tb_sd_cmd.sv
// tb_sd_cmd: scoreboard bench for sd_cmd with a card model and an arithmetic CRC7 reference.
// Long-response cases are exercised when SD_CMD_LONG_RESPONSE_EN is defined.
module tb_sd_cmd;
  localparam int TIMEOUT = 64;

  typedef struct packed {
    logic [5:0]   idx;
    logic [127:0] resp;
    logic         tout;
    logic         crc;
  } res_t;

  logic         clk, rst_n, strobe_r, strobe_f, cmd_in;
  logic         start, skip, lng, ign;
  logic [5:0]   index;
  logic [31:0]  argument;
  logic         oe, cmd_out, busy, done, tout, crcerr;
  logic [5:0]   rsp_index;
  logic [127:0] rsp;

  bit strobe_en = 1'b1;
  int div = 4;
  int fall_ph = 2;
  int n_checks = 0;
  int n_err = 0;
  int done_cnt = 0;

  res_t        exp_q[$];
  logic [47:0] exp_tx_q[$];
  logic [47:0] tx_bits;
  int          tx_n;
  logic        prev_oe;

  sd_cmd #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk                   (clk),
    .i_reset                 (rst_n),
    .i_sd_clk_strobe_rising  (strobe_r),
    .i_sd_clk_strobe_falling (strobe_f),
    .o_sd_cmd_oe             (oe),
    .o_sd_cmd_out            (cmd_out),
    .i_sd_cmd_in             (cmd_in),
    .i_start                 (start),
    .i_index                 (index),
    .i_argument              (argument),
    .i_skip_response         (skip),
    .i_long_response         (lng),
    .i_ignore_crc            (ign),
    .o_busy                  (busy),
    .o_done                  (done),
    .o_index                 (rsp_index),
    .o_response              (rsp),
    .o_error_timeout         (tout),
    .o_error_crc             (crcerr)
  );

  // ---------------- clock / reset / strobes ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin : strobe_gen
    int ph;
    ph = 0;
    strobe_r = 1'b0;
    strobe_f = 1'b0;
    forever begin
      @(negedge clk);
      if (strobe_en) begin
        strobe_r = (ph == 0);
        strobe_f = (ph == fall_ph);
        ph = (ph + 1 >= div) ? 0 : ph + 1;
      end else begin
        strobe_r = 1'b0;
        strobe_f = 1'b0;
      end
    end
  end

  initial begin
    #(900_000);
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Remainder of (data * x^7) divided by x^7+x^3+1, by plain long division.
  function automatic logic [6:0] crc7_div(input logic [119:0] data, input int n);
    logic [126:0] v;
    v = {data, 7'b0};
    for (int i = n + 6; i >= 7; i--) begin
      if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
    end
    return v[6:0];
  endfunction

  function automatic logic [47:0] cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] d;
    d = {2'b01, idx, arg};
    return {d, crc7_div({80'b0, d}, 40), 1'b1};
  endfunction

  function automatic logic [135:0] short_rsp(input logic [5:0] idx, input logic [31:0] arg,
                                             input logic [6:0] crc_xor, input logic endb);
    logic [39:0] d;
    d = {2'b00, idx, arg};
    return {88'b0, d, crc7_div({80'b0, d}, 40) ^ crc_xor, endb};
  endfunction

  function automatic res_t mk_res(input logic [5:0] idx, input logic [127:0] r,
                                  input logic t, input logic c);
    res_t e;
    e.idx = idx; e.resp = r; e.tout = t; e.crc = c;
    return e;
  endfunction

  // ---------------- monitors ----------------
  always @(posedge clk) begin : tx_mon
    logic fs, rs;
    fs = strobe_f;
    rs = rst_n;
    #1;
    if (!rs) begin
      tx_n = 0;
      tx_bits = '0;
      prev_oe = 1'b0;
    end else begin
      if (fs && oe) begin
        tx_bits = {tx_bits[46:0], cmd_out};
        tx_n++;
      end
      if (prev_oe && !oe) begin
        if (exp_tx_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL tx_unexpected: got frame %0h expected none", tx_bits);
        end else begin
          chk("tx_frame", tx_bits, exp_tx_q.pop_front());
          chk("tx_len", tx_n, 48);
          chk("tx_release_high", cmd_out, 1'b1);
        end
        tx_n = 0;
      end
      prev_oe = oe;
    end
  end

  always @(negedge clk) begin : rsp_mon
    res_t e;
    if (rst_n && done) begin
      done_cnt++;
      chk("done_busy_low", busy, 1'b0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL done_unexpected: got done expected none");
      end else begin
        e = exp_q.pop_front();
        chk("rsp_index", rsp_index, e.idx);
        chk("rsp_data", rsp, e.resp);
        chk("rsp_timeout", tout, e.tout);
        chk("rsp_crc_err", crcerr, e.crc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic count_rising(input int n);
    int c, t;
    c = 0;
    t = 0;
    while (c < n && t < 20000) begin
      @(posedge clk);
      t++;
      if (strobe_r) c++;
    end
  endtask

  // Card: idles high for `delay` rising strobes after the host releases CMD, then sends the frame.
  task automatic card_send(input logic [135:0] fr, input int nb, input int delay, input int pause);
    int t;
    if (pause > 0) begin
      count_rising(delay / 2);
      @(negedge clk);
      strobe_en = 1'b0;
      repeat (pause) @(negedge clk);
      chk("pause_busy", busy, 1'b1);
      chk("pause_no_timeout", tout, 1'b0);
      strobe_en = 1'b1;
      count_rising(delay - delay / 2);
    end else begin
      count_rising(delay);
    end
    #1;
    for (int i = nb - 1; i >= 0; i--) begin
      cmd_in = fr[i];
      t = 0;
      do begin
        @(posedge clk);
        t++;
      end while (!strobe_r && t < 1000);
      #1;
    end
    cmd_in = 1'b1;
  endtask

  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic sk,
                         input logic lg, input logic ig, input logic [47:0] exp_tx,
                         input logic [135:0] rframe, input int rbits, input int delay,
                         input res_t e, input int pause, input bit poke);
    int t, dc;
    t = 0;
    while (busy && t < 10000) begin
      @(negedge clk);
      t++;
    end
    exp_tx_q.push_back(exp_tx);
    exp_q.push_back(e);
    dc = done_cnt;
    @(negedge clk);
    start = 1'b1; index = idx; argument = arg; skip = sk; lng = lg; ign = ig;
    @(negedge clk);
    start = 1'b0;
    index = 6'($urandom); argument = $urandom;
    skip = 1'($urandom); lng = 1'($urandom); ign = 1'($urandom);
    t = 0;
    while (!oe && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (poke) begin
      repeat (30) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    t = 0;
    while (oe && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!sk && delay < TIMEOUT) card_send(rframe, rbits, delay, pause);
    t = 0;
    while (done_cnt == dc && t < 10000) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", done_cnt != dc, 1'b1);
    repeat (5) @(negedge clk);
    chk("result_hold", {rsp_index, rsp, tout, crcerr}, e);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    logic [5:0]   cidx, ridx;
    logic [31:0]  carg, rarg;
    logic         sk, lg, ig, corrupt, end0;
    logic [6:0]   cx;
    logic [127:0] pl;
    logic [135:0] rf;
    int           rb, dly, t, dc;
    res_t         e;

    rst_n = 1'b0; cmd_in = 1'b1; start = 1'b0; index = '0; argument = '0;
    skip = 1'b0; lng = 1'b0; ign = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_oe", oe, 1'b0);
    chk("reset_out", cmd_out, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_index", rsp_index, 6'd0);
    chk("reset_resp", rsp, 128'd0);
    chk("reset_timeout", tout, 1'b0);
    chk("reset_crc", crcerr, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // CMD0, no response
    run_cmd(6'd0, 32'd0, 1'b1, 1'b0, 1'b0, 48'h400000000095, '0, 0, 0,
            mk_res(6'd0, 128'd0, 1'b0, 1'b0), 0, 1'b0);
    // CMD8 good R7, plus an ignored start request mid-frame
    run_cmd(6'd8, 32'h1AA, 1'b0, 1'b0, 1'b0, 48'h48000001AA87, {88'b0, 48'h08000001AA13}, 48, 5,
            mk_res(6'd8, 128'h1AA, 1'b0, 1'b0), 0, 1'b1);
    // CMD8 with bad response CRC
    run_cmd(6'd8, 32'h1AA, 1'b0, 1'b0, 1'b0, 48'h48000001AA87, {88'b0, 48'h08000001AA15}, 48, 5,
            mk_res(6'd8, 128'h1AA, 1'b0, 1'b1), 0, 1'b0);
    // CMD17: no start bit within TIMEOUT, then the last legal start position
    carg = $urandom;
    run_cmd(6'd17, carg, 1'b0, 1'b0, 1'b0, cmd_frame(6'd17, carg), '0, 0, TIMEOUT,
            mk_res(6'd0, 128'd0, 1'b1, 1'b0), 0, 1'b0);
    rarg = $urandom;
    run_cmd(6'd17, carg, 1'b0, 1'b0, 1'b0, cmd_frame(6'd17, carg),
            short_rsp(6'd17, rarg, 7'd0, 1'b1), 48, TIMEOUT - 1,
            mk_res(6'd17, {96'b0, rarg}, 1'b0, 1'b0), 0, 1'b0);
    // ACMD41 with R3 (CRC field all ones), then with end bit 0
    run_cmd(6'd41, 32'h40FF8000, 1'b0, 1'b0, 1'b1, cmd_frame(6'd41, 32'h40FF8000),
            {88'b0, 48'h3F00FF8000FF}, 48, 3, mk_res(6'h3F, 128'h00FF8000, 1'b0, 1'b0), 0, 1'b0);
    run_cmd(6'd41, 32'h40FF8000, 1'b0, 1'b0, 1'b1, cmd_frame(6'd41, 32'h40FF8000),
            {88'b0, 48'h3F00FF8000FE}, 48, 3, mk_res(6'h3F, 128'h00FF8000, 1'b0, 1'b1), 0, 1'b0);
    // SD clock stopped during the response wait: no timeout may accrue
    rarg = $urandom;
    run_cmd(6'd13, 32'h0001_0000, 1'b0, 1'b0, 1'b0, cmd_frame(6'd13, 32'h0001_0000),
            short_rsp(6'd13, rarg, 7'd0, 1'b1), 48, 40,
            mk_res(6'd13, {96'b0, rarg}, 1'b0, 1'b0), 400, 1'b0);

    // Reset during TX bit 20, with a start request while busy
    @(negedge clk);
    start = 1'b1; index = 6'd17; argument = $urandom; skip = 1'b0;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (tx_n < 20 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    start = 1'b1; index = 6'd24;
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_oe", oe, 1'b0);
    chk("abort_busy", busy, 1'b0);
    rst_n = 1'b1;
    dc = done_cnt;
    repeat (300) @(negedge clk);
    chk("abort_no_done", done_cnt, dc);
    chk("abort_idle_oe", oe, 1'b0);

    // Randomised transactions, including coincident strobes and odd dividers
    for (int k = 0; k < 25; k++) begin
      div = $urandom_range(2, 6);
      fall_ph = $urandom_range(0, div - 1);
      cidx = 6'($urandom); carg = $urandom;
      ridx = 6'($urandom); rarg = $urandom;
      sk = ($urandom_range(0, 4) == 0);
      lg = 1'($urandom);
      ig = 1'($urandom);
      dly = ($urandom_range(0, 5) == 0) ? $urandom_range(TIMEOUT, TIMEOUT + 6) : $urandom_range(0, TIMEOUT - 1);
      corrupt = ($urandom_range(0, 3) == 0);
      end0 = ($urandom_range(0, 7) == 0);
      cx = corrupt ? 7'($urandom_range(1, 127)) : 7'd0;
      rf = '0;
      rb = 48;
      e = mk_res(6'd0, 128'd0, 1'b0, 1'b0);
      if (!sk && dly >= TIMEOUT) begin
        e.tout = 1'b1;
      end else if (!sk) begin
`ifdef SD_CMD_LONG_RESPONSE_EN
        if (lg) begin
          pl = {$urandom, $urandom, $urandom, $urandom};
          rf = {8'h3F, pl[119:0], crc7_div(pl[119:0], 120) ^ cx, !end0};
          rb = 136;
          e.resp = rf[127:0];
        end else begin
          rf = short_rsp(ridx, rarg, cx, !end0);
          e.idx = ridx;
          e.resp = {96'b0, rarg};
        end
`else
        rf = short_rsp(ridx, rarg, cx, !end0);
        e.idx = ridx;
        e.resp = {96'b0, rarg};
`endif
        e.crc = (corrupt && !ig) || end0;
      end
      run_cmd(cidx, carg, sk, lg, ig, cmd_frame(cidx, carg), rf, rb, dly, e, 0, 1'b0);
    end

    repeat (20) @(negedge clk);
    chk("rsp_queue_drained", exp_q.size(), 0);
    chk("tx_queue_drained", exp_tx_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/sd_cmd.md
Name: sd_cmd

Overview:
- Serial SD CMD-line engine. It consumes the SD clock rising/falling strobes from the SD clock generator.
- Transmits a 48-bit command frame with CRC7, optionally receives the card response, checks its CRC/framing, and reports the result to the SD controller FSM.
- Sits between the controller registers and the CMD pad (tri-state via output-enable).

Parameters:
TIMEOUT, 64, max rising strobes to wait for response start bit (NCR), 8-bit range 1..255

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous reset, active-low
i_sd_clk_strobe_rising  in  1  one-cycle pulse, SD clock rising edge
i_sd_clk_strobe_falling  in  1  one-cycle pulse, SD clock falling edge
o_sd_cmd_oe  out  1  CMD pad output enable
o_sd_cmd_out  out  1  CMD pad output value
i_sd_cmd_in  in  1  CMD pad input (pulled up externally)
i_start  in  1  one-cycle request; ignored while o_busy
i_index  in  6  command index, captured at i_start
i_argument  in  32  command argument, captured at i_start
i_skip_response  in  1  no response expected (e.g. CMD0), captured at i_start
i_long_response  in  1  136-bit R2 response expected, captured at i_start
i_ignore_crc  in  1  suppress CRC check (R3), captured at i_start
o_busy  out  1  transaction in progress
o_done  out  1  one-cycle completion pulse
o_index  out  6  received response index field
o_response  out  128  short: [31:0]=argument field, rest 0; long: bits 127..1 of R2 payload plus CRC byte, i.e. [127:0]
o_error_timeout  out  1  no start bit within TIMEOUT
o_error_crc  out  1  CRC mismatch or end bit = 0

Behaviour:
- Reset (i_reset low at clock edge) values:
  - o_sd_cmd_oe=0, o_sd_cmd_out=1, o_busy=0, o_done=0, o_index=0, o_response=0, both errors=0, state IDLE.
  - Reset mid-transaction aborts at once: OE drops the next cycle and no o_done is issued.
- States: IDLE, TX, RX_WAIT, RX.
- IDLE + i_start:
  - Load frame {0,1,index,argument}, clear CRC7, clear errors/response/index.
  - o_busy=1 next cycle; go to TX.
- TX:
  - On each falling strobe drive the next bit MSB-first with OE=1.
  - Bits 47..8 feed CRC7 (poly x^7+x^3+1, init 0); bits 7..1 are the CRC, bit 0 is end bit 1.
  - The first bit appears on the first falling strobe after i_start is accepted.
  - On the falling strobe following the end bit: OE=0, out=1.
    - If skip_response: o_done pulse the following cycle, o_busy=0, go to IDLE.
    - Else go to RX_WAIT with wait counter = 0.
- RX_WAIT:
  - On each rising strobe sample i_sd_cmd_in.
  - If it is 0: start bit; go to RX, bit count = 1.
  - Else increment the counter. When it reaches TIMEOUT: o_error_timeout=1, o_done pulse, IDLE.
- RX:
  - Shift i_sd_cmd_in on each rising strobe.
  - Total frame length is 48 bits (short) or 136 bits (long).
  - CRC7 covers:
    - short: bits 47..8;
    - long: bits 127..8 of the 128-bit payload after the 8-bit header.
- After the end bit is sampled:
  - o_index = frame bits 45..40 (short only; long leaves 0).
  - o_response is updated.
  - o_error_crc = (crc mismatch && !ignore_crc) || end bit == 0.
  - o_done pulse the next cycle; o_busy low with o_done; IDLE.
- Results hold until the next accepted i_start.
- Strobes only advance TX/RX. With the clock stopped (no strobes), the block holds its state indefinitely and no timeout occurs.
- Simultaneous rising+falling strobe: both actions apply in the same cycle, each only in its own state.
- Transmission-bit check (bit 46 = 0) is not performed.

Optional Feature:
- Macro: SD_CMD_LONG_RESPONSE_EN.
- Defined: 136-bit R2 reception as specified, 128-bit response path.
- Undefined:
  - i_long_response is ignored and treated as 0.
  - o_response[127:32] is tied to 0.
  - The RX shift register is 48 bits.

Test Plan:
- CMD0, arg 0, skip_response=1, strobes at DIV_4 rate -> CMD line shows 0x400000000095 MSB-first on falling strobes; o_done once after the end bit is released; no errors.
- CMD8 arg 0x000001AA -> TX 0x48000001AA87. Card returns 0x08000001AA13 starting 5 rising strobes later -> o_index=8, o_response[31:0]=0x000001AA, no errors.
- Same as the CMD8 case with response CRC byte 0x15 -> o_error_crc=1, response still latched.
- CMD17, no start bit (line held high) -> after 64 rising strobes o_error_timeout=1, o_done pulse, o_busy=0.
- ACMD41 with i_ignore_crc=1, card returns R3 0x3F00FF8000FF -> o_response[31:0]=0x00FF8000, no CRC error. Repeat with end bit 0 -> o_error_crc=1.
- Reset low during TX bit 20, plus i_start while busy -> OE=0 next cycle, no o_done; second i_start ignored, no extra frame sent.
